seg_msg_scroller: RTL and testbench

SEG_MSG_SCROLLER -- requirements
Module: seg_msg_scroller

---
 rtl/seg_pkg.sv | 39 +++
 rtl/seg_debounce.sv | 56 +++++
 rtl/seg_msg_scroller.sv | 172 +++++++++++++++++
 tb/tb_seg_msg_scroller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 7-segment message scroller: segment bit order,
// glyph constants and the default message table.
//
// Segment byte layout, MSB first: {dp, a, b, c, d, e, f, g}.
// -----------------------------------------------------------------------------
package seg_pkg;

    // Bit positions inside a segment byte.
    localparam int SEG_DP = 7;
    localparam int SEG_A  = 6;
    localparam int SEG_B  = 5;
    localparam int SEG_C  = 4;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 2;
    localparam int SEG_F  = 1;
    localparam int SEG_G  = 0;

    localparam logic [7:0] GLY_BLANK = 8'h00;
    localparam logic [7:0] GLY_DP    = 8'h80;
    localparam logic [7:0] GLY_S     = 8'h5B;
    localparam logic [7:0] GLY_E     = 8'h4F;
    localparam logic [7:0] GLY_N     = 8'h15;
    localparam logic [7:0] GLY_O     = 8'h7E;
    localparam logic [7:0] GLY_L     = 8'h0E;
    localparam logic [7:0] GLY_G     = 8'h5F;
    localparam logic [7:0] GLY_U     = 8'h3E;

    localparam int MSG_DEF_LEN = 14;

    // Character 0 is a lone decimal point so the start of the message is
    // visible even without the dp marker option.
    localparam logic [7:0] MSG_GLYPHS [MSG_DEF_LEN] = '{
        GLY_DP, GLY_S, GLY_E, GLY_N, GLY_O, GLY_L, GLY_G,
        GLY_U,  GLY_L, GLY_G, GLY_O, GLY_N, GLY_U, GLY_L
    };

endpackage

// File: rtl/seg_debounce.sv
// -----------------------------------------------------------------------------
// seg_debounce
// Two-flop synchroniser followed by a stability counter. The internal level
// only follows the synchronised input after it has differed from the level
// for DEB_CYC consecutive cycles; any return to the old value restarts the
// count.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   raw    in   unsynchronised push-button input
//   rise   out  one-cycle pulse when the level goes 0 -> 1
// -----------------------------------------------------------------------------
module seg_debounce #(
    parameter int DEB_CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic [1:0]       sync_q;
    logic             sync;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             settled;

    assign sync    = sync_q[1];
    assign settled = (cnt == CNT_W'(DEB_CYC - 1));

    // The level flips in the cycle where the input has differed for the
    // DEB_CYC-th time, so the rise pulse is taken combinationally from it.
    assign rise = sync && !level && settled;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            level  <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (sync == level) begin
                cnt <= '0;
            end else if (settled) begin
                cnt   <= '0;
                level <= sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_msg_scroller.sv
// -----------------------------------------------------------------------------
// seg_msg_scroller
// Scrolls the message table from seg_pkg across DIGITS multiplexed 7-segment
// digits. Steps come from a debounced push-button (manual mode) or from a
// free-running prescaler (auto mode).
//
// Build option: define SEG_DP_MARK_EN to force the dp segment on whichever
// digit is currently showing character 0.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   step_in     in   raw push-button, rising edge steps in manual mode
//   mode        in   0 = manual, 1 = auto-scroll
//   dir         in   0 = forward, 1 = reverse
//   pause       in   1 = suppress steps, prescaler holds
//   seg_out     out  registered {dp,a,b,c,d,e,f,g} for the active digit
//   dig_sel     out  one-hot active digit
//   index_out   out  message start index
//   wrap_pulse  out  one-cycle pulse after a step that wrapped the index
// -----------------------------------------------------------------------------
module seg_msg_scroller
    import seg_pkg::*;
#(
    parameter int MSG_LEN  = 14,
    parameter int DIGITS   = 4,
    parameter int DEB_CYC  = 50000,
    parameter int AUTO_DIV = 12000000,
    parameter int SCAN_DIV = 12000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       step_in,
    input  logic                       mode,
    input  logic                       dir,
    input  logic                       pause,
    output logic [7:0]                 seg_out,
    output logic [DIGITS-1:0]          dig_sel,
    output logic [$clog2(MSG_LEN)-1:0] index_out,
    output logic                       wrap_pulse
);

    localparam int IDX_W = $clog2(MSG_LEN);
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic             rise;
    logic             mode_q;
    logic             mode_chg;
    logic [PRE_W-1:0] pre, pre_nxt;
    logic             step;
    logic [IDX_W-1:0] idx_nxt;
    logic             wrap;
    logic [SC_W-1:0]  scan_cnt, scan_nxt;
    logic             scan_tc;
    logic [DIG_W-1:0] dig_q, dig_nxt;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] char_idx;
    logic [7:0]       glyph;
    logic [7:0]       seg_nxt;

    seg_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (step_in),
        .rise  (rise)
    );

    assign mode_chg = (mode != mode_q);

    // Step source selection; a mode change always costs one quiet cycle.
    always_comb begin
        step    = 1'b0;
        pre_nxt = pre;
        if (mode_chg) begin
            pre_nxt = '0;
        end else if (!pause) begin
            if (mode) begin
                if (pre == PRE_W'(AUTO_DIV - 1)) begin
                    pre_nxt = '0;
                    step    = 1'b1;
                end else begin
                    pre_nxt = pre + 1'b1;
                end
            end else begin
                step = rise;
            end
        end
    end

    always_comb begin
        if (!dir) begin
            wrap    = (index_out == IDX_W'(MSG_LEN - 1));
            idx_nxt = wrap ? '0 : index_out + 1'b1;
        end else begin
            wrap    = (index_out == '0);
            idx_nxt = wrap ? IDX_W'(MSG_LEN - 1) : index_out - 1'b1;
        end
    end

    assign scan_tc  = (scan_cnt == SC_W'(SCAN_DIV - 1));
    assign scan_nxt = scan_tc ? '0 : scan_cnt + 1'b1;

    always_comb begin
        dig_nxt = dig_q;
        if (scan_tc) begin
            dig_nxt = (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
        end
    end

    generate
        if (DIGITS == 1) begin : g_single
            assign dig_sel = 1'b1;
        end else begin : g_multi
            assign dig_sel = DIGITS'(1) << dig_q;
        end
    endgenerate

    // seg_out is loaded with the digit that becomes active on this edge so
    // that segments and digit select switch together. DIGITS <= MSG_LEN keeps
    // the sum below 2*MSG_LEN, so one conditional subtract is a full modulo.
    always_comb begin
        sum      = {1'b0, index_out} + (IDX_W + 1)'(dig_nxt);
        char_idx = sum[IDX_W-1:0];
        if (sum >= (IDX_W + 1)'(MSG_LEN)) begin
            char_idx = IDX_W'(sum - (IDX_W + 1)'(MSG_LEN));
        end
    end

    // Characters beyond the default table are shown blank.
    always_comb begin
        glyph = GLY_BLANK;
        for (int i = 0; i < MSG_DEF_LEN; i++) begin
            if (int'(char_idx) == i) begin
                glyph = MSG_GLYPHS[i];
            end
        end
    end

    always_comb begin
        seg_nxt = glyph;
`ifdef SEG_DP_MARK_EN
        if (char_idx == '0) begin
            seg_nxt[SEG_DP] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= 1'b0;
            pre        <= '0;
            index_out  <= '0;
            wrap_pulse <= 1'b0;
            scan_cnt   <= '0;
            dig_q      <= '0;
            seg_out    <= 8'h00;
        end else begin
            mode_q     <= mode;
            pre        <= pre_nxt;
            wrap_pulse <= step && wrap;
            if (step) begin
                index_out <= idx_nxt;
            end
            scan_cnt <= scan_nxt;
            dig_q    <= dig_nxt;
            seg_out  <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_msg_scroller.sv
// -----------------------------------------------------------------------------
// tb_seg_msg_scroller
// Directed-plus-random bench for seg_msg_scroller with small timing parameters.
// The expected index, digit and segment values come from modular arithmetic
// on the message position and the cycle count since reset release.
// -----------------------------------------------------------------------------
module tb_seg_msg_scroller;

    localparam int MSG_LEN  = 14;
    localparam int DIGITS   = 4;
    localparam int DEB_CYC  = 4;
    localparam int AUTO_DIV = 10;
    localparam int SCAN_DIV = 2;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       step_in = 1'b0;
    logic       mode    = 1'b0;
    logic       dir     = 1'b0;
    logic       pause   = 1'b0;
    logic [7:0] seg_out;
    logic [3:0] dig_sel;
    logic [3:0] index_out;
    logic       wrap_pulse;

    int checks   = 0;
    int failures = 0;

    int         cyc      = 0;
    int         n_chg    = 0;
    int         n_wrap   = 0;
    logic [3:0] last_idx = '0;
    int         model_idx = 0;

    logic [7:0] ref_glyph [MSG_LEN] = '{
        8'h80, 8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F,
        8'h3E, 8'h0E, 8'h5F, 8'h7E, 8'h15, 8'h3E, 8'h0E
    };

    always #5 clk = ~clk;

    seg_msg_scroller #(
        .MSG_LEN  (MSG_LEN),
        .DIGITS   (DIGITS),
        .DEB_CYC  (DEB_CYC),
        .AUTO_DIV (AUTO_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_in    (step_in),
        .mode       (mode),
        .dir        (dir),
        .pause      (pause),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .index_out  (index_out),
        .wrap_pulse (wrap_pulse)
    );

    // Clock edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Running totals of index changes and wrap-pulse cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            if (index_out !== last_idx) n_chg++;
            if (wrap_pulse) n_wrap++;
        end
        last_idx = index_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_disp(input string tag);
        int         d;
        int         c;
        logic [7:0] e;
        d = (cyc / SCAN_DIV) % DIGITS;
        c = (model_idx + d) % MSG_LEN;
        e = ref_glyph[c];
`ifdef SEG_DP_MARK_EN
        if (c == 0) e = e | 8'h80;
`endif
        chk({tag, "_dig"}, 32'(dig_sel), 32'(1) << d);
        chk({tag, "_seg"}, 32'(seg_out), 32'(e));
    endtask

    task automatic press(input logic dv, input int hold, input string tag);
        int c0;
        int w0;
        int exp_w;
        c0 = n_chg;
        w0 = n_wrap;
        dir = dv;
        step_in = 1'b1;
        tick(hold);
        step_in = 1'b0;
        tick(12);
        exp_w = 0;
        if (!dv) begin
            if (model_idx == MSG_LEN - 1) exp_w = 1;
            model_idx = (model_idx + 1) % MSG_LEN;
        end else begin
            if (model_idx == 0) exp_w = 1;
            model_idx = (model_idx + MSG_LEN - 1) % MSG_LEN;
        end
        chk({tag, "_steps"}, 32'(n_chg - c0), 32'(1));
        chk({tag, "_idx"}, 32'(index_out), 32'(model_idx));
        chk({tag, "_wrap"}, 32'(n_wrap - w0), 32'(exp_w));
        check_disp(tag);
    endtask

    // Expects to be entered right after a step edge (or one edge after a
    // mode change), so the next step lands AUTO_DIV edges later.
    task automatic auto_run(input int n, input string tag);
        logic wrapping;
        for (int s = 0; s < n; s++) begin
            tick(AUTO_DIV - 1);
            chk({tag, "_hold"}, 32'(index_out), 32'(model_idx));
            check_disp(tag);
            wrapping  = dir ? (model_idx == 0) : (model_idx == MSG_LEN - 1);
            model_idx = dir ? (model_idx + MSG_LEN - 1) % MSG_LEN : (model_idx + 1) % MSG_LEN;
            tick(1);
            chk({tag, "_idx"}, 32'(index_out), 32'(model_idx));
            chk({tag, "_wrap"}, 32'(wrap_pulse), 32'(wrapping));
        end
    endtask

    initial begin
        int c0;
        int w0;
        int k;
        int h;
        int r;

        // Reset state
        tick(3);
        chk("rst_idx", 32'(index_out), 32'(0));
        chk("rst_seg", 32'(seg_out), 32'(0));
        chk("rst_dig", 32'(dig_sel), 32'(1));
        chk("rst_wrap", 32'(wrap_pulse), 32'(0));

        rst_n = 1'b1;
        tick(1);
        chk("first_seg", 32'(seg_out), 32'h80);
        chk("first_dig", 32'(dig_sel), 32'(1));

        // Bounce rejection: fixed 2-cycle toggling, then random short runs
        c0 = n_chg;
        for (int i = 0; i < 10; i++) begin
            step_in = ~step_in;
            tick(2);
        end
        step_in = 1'b0;
        tick(4);
        k = 0;
        while (k < 20) begin
            h = $urandom_range(1, DEB_CYC - 1);
            step_in = ~step_in;
            tick(h);
            k += h;
        end
        step_in = 1'b0;
        tick(12);
        chk("bounce_steps", 32'(n_chg - c0), 32'(0));
        chk("bounce_idx", 32'(index_out), 32'(0));
        check_disp("bounce");

        // Manual step, held high for 10 cycles
        press(1'b0, 10, "man_first");
        for (int i = 0; i < 2 * DIGITS * SCAN_DIV && dig_sel != 4'b0001; i++) tick(1);
        chk("man_dig0_sel", 32'(dig_sel), 32'(1));
        chk("man_dig0_seg", 32'(seg_out), 32'h5B);

        for (int i = 0; i < 4; i++) begin
            press(1'($urandom_range(0, 1)), $urandom_range(DEB_CYC + 2, 10), "man_rand");
        end

        // Forward auto scroll ending on the wrap to 0
        dir  = 1'b0;
        mode = 1'b1;
        tick(1);
        r  = model_idx;
        w0 = n_wrap;
        auto_run((r == 0) ? MSG_LEN : MSG_LEN - r, "fwd");
        chk("fwd_end_idx", 32'(index_out), 32'(0));
        chk("fwd_wrap_cnt", 32'(n_wrap - w0), 32'(1));

        // Reverse wrap 0 -> 13
        dir = 1'b1;
        auto_run(1, "rev");
        chk("rev_idx13", 32'(index_out), 32'(MSG_LEN - 1));
        chk("fwdrev_wrap_cnt", 32'(n_wrap - w0), 32'(2));

        // Pause holds the prescaler; the step resumes with the remaining count
        k = $urandom_range(1, AUTO_DIV - 2);
        tick(k);
        pause = 1'b1;
        c0 = n_chg;
        tick(50);
        chk("pause_steps", 32'(n_chg - c0), 32'(0));
        chk("pause_idx", 32'(index_out), 32'(model_idx));
        check_disp("pause");
        pause = 1'b0;
        tick(AUTO_DIV - k - 1);
        chk("pause_resume_hold", 32'(index_out), 32'(model_idx));
        tick(1);
        model_idx = (model_idx + MSG_LEN - 1) % MSG_LEN;
        chk("pause_resume_idx", 32'(index_out), 32'(model_idx));

        // Move to index 5 and reset while digit 2 is active
        dir = 1'b0;
        auto_run((5 - model_idx + MSG_LEN) % MSG_LEN, "to5");
        for (int i = 0; i < 2 * DIGITS * SCAN_DIV && dig_sel != 4'b0100; i++) tick(1);
        chk("pre_rst_dig", 32'(dig_sel), 32'b0100);
        chk("pre_rst_idx", 32'(index_out), 32'(5));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_idx", 32'(index_out), 32'(0));
        chk("mid_rst_dig", 32'(dig_sel), 32'b0001);
        chk("mid_rst_seg", 32'(seg_out), 32'(0));
        chk("mid_rst_wrap", 32'(wrap_pulse), 32'(0));
        mode = 1'b0;
        model_idx = 0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("rel_seg", 32'(seg_out), 32'h80);
        chk("rel_dig", 32'(dig_sel), 32'(1));
        tick(3);
        check_disp("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
